// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with boot hold, redirect, trap vectoring and halt/resume.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              BOOT_HOLD    = 1,
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign_trap,
  output logic [1:0]      state
);
  localparam int CW = $clog2(BOOT_HOLD + 2);
  localparam logic [XLEN-1:0] AMASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
  logic            mis_q, mis_d;
  logic            run, misal, to_trap;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (BOOT_HOLD == 0) ? RUN : BOOT;
      cnt_q   <= CW'(BOOT_HOLD);
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
    end
  end
  // halt only wins when neither trap nor redirect is requested in the same cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q <= CW'(1)) ? RUN : BOOT;
      end
      RUN:     state_d = (!trap_req && !redirect && halt_req) ? HALT : RUN;
      HALT:    state_d = resume ? RUN : HALT;
      default: state_d = BOOT;
    endcase
  end
  always_comb begin
    run     = state_q == RUN;
    misal   = redirect && |(redirect_target & AMASK);
    to_trap = run && (trap_req || misal);
    pc_d    = !run ? pc_q :
              to_trap ? TRAP_VECTOR :
              redirect ? redirect_target :
              (halt_req || stall) ? pc_q : pc_q + XLEN'(INC);
    epc_d   = to_trap ? pc_q : epc_q;
    mis_d   = run && !trap_req && misal;
  end
  assign pc            = pc_q;
  assign pc_next_seq   = pc_q + XLEN'(INC);
  assign pc_valid      = state_q == RUN;
  assign epc           = epc_q;
  assign misalign_trap = mis_q;
  assign state         = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random checks of two pc_sequencer variants (ALIGN_BITS 2 and 1) against a behavioural model.
module tb_pc_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic stall = 0, redirect = 0, trap_req = 0, halt_req = 0, resume = 0;
  logic [31:0] tgt = '0;
  logic [31:0] pc0, nxt0, epc0, pc1, nxt1, epc1;
  logic v0, mis0, v1, mis1;
  logic [1:0] st0, st1;
  int checks = 0, errors = 0;
  logic [31:0] mpc[2], mepc[2];
  bit mmis[2], mhalt[2];
  int mboot[2];
  int abytes[2] = '{4, 2};

  always #5 clk = ~clk;

  pc_sequencer #(.ALIGN_BITS(2)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_target(tgt),
    .trap_req(trap_req), .halt_req(halt_req), .resume(resume), .pc(pc0), .pc_next_seq(nxt0),
    .pc_valid(v0), .epc(epc0), .misalign_trap(mis0), .state(st0));
  pc_sequencer #(.ALIGN_BITS(1)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_target(tgt),
    .trap_req(trap_req), .halt_req(halt_req), .resume(resume), .pc(pc1), .pc_next_seq(nxt1),
    .pc_valid(v1), .epc(epc1), .misalign_trap(mis1), .state(st1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mpc[k] = 0; mepc[k] = 0; mmis[k] = 0; mhalt[k] = 0; mboot[k] = 1;
    end
  endtask

  // one clock edge of the behavioural model, using the currently driven inputs
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      mmis[k] = 0;
      if (mboot[k] > 0) mboot[k]--;
      else if (mhalt[k]) begin
        if (resume) mhalt[k] = 0;
      end else if (trap_req) begin
        mepc[k] = mpc[k]; mpc[k] = 32'h100;
      end else if (redirect && (tgt % abytes[k]) != 0) begin
        mepc[k] = mpc[k]; mpc[k] = 32'h100; mmis[k] = 1;
      end else if (redirect) mpc[k] = tgt;
      else if (halt_req) mhalt[k] = 1;
      else if (!stall) mpc[k] = mpc[k] + 32'd4;
    end
  endtask

  function automatic logic [31:0] mstate(int k);
    return mboot[k] > 0 ? 32'd0 : mhalt[k] ? 32'd2 : 32'd1;
  endfunction

  task automatic check_all();
    chk("u0.pc", pc0, mpc[0]);
    chk("u0.pc_next_seq", nxt0, mpc[0] + 32'd4);
    chk("u0.pc_valid", {31'd0, v0}, {31'd0, mstate(0) == 1});
    chk("u0.epc", epc0, mepc[0]);
    chk("u0.misalign_trap", {31'd0, mis0}, {31'd0, mmis[0]});
    chk("u0.state", {30'd0, st0}, mstate(0));
    chk("u1.pc", pc1, mpc[1]);
    chk("u1.pc_valid", {31'd0, v1}, {31'd0, mstate(1) == 1});
    chk("u1.epc", epc1, mepc[1]);
    chk("u1.misalign_trap", {31'd0, mis1}, {31'd0, mmis[1]});
    chk("u1.state", {30'd0, st1}, mstate(1));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    stall = 0; redirect = 0; trap_req = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 0;
    tick();
    chk("boot_swallow_pc", pc0, 32'h0);
    chk("boot_state_run", {30'd0, st0}, 32'd1);
    tick();
    chk("boot_first_inc", pc0, 32'h4);
    tick(); tick(); tick();
    chk("seq_pc_10", pc0, 32'h10);
    redirect = 1; tgt = 32'h200; stall = 1; halt_req = 1;
    tick();
    chk("redirect_over_stall_halt", pc0, 32'h200);
    chk("redirect_no_halt", {30'd0, st0}, 32'd1);
    idle(); redirect = 1; tgt = 32'h24;
    tick();
    tgt = 32'h202;
    tick();
    chk("misal_pc", pc0, 32'h100);
    chk("misal_epc", epc0, 32'h24);
    chk("misal_flag", {31'd0, mis0}, 32'd1);
    chk("align1_pc", pc1, 32'h202);
    idle();
    tick();
    chk("misal_pulse_end", {31'd0, mis0}, 32'd0);
    redirect = 1; tgt = 32'h40;
    tick();
    trap_req = 1; tgt = 32'h200;
    tick();
    chk("trap_pc", pc0, 32'h100);
    chk("trap_epc", epc0, 32'h40);
    chk("trap_no_misal", {31'd0, mis0}, 32'd0);
    idle(); redirect = 1; tgt = 32'h8;
    tick();
    idle(); halt_req = 1;
    tick();
    chk("halt_state", {30'd0, st0}, 32'd2);
    halt_req = 0; trap_req = 1; stall = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_hold_pc", pc0, 32'h8);
    end
    idle(); resume = 1;
    tick();
    chk("resume_state", {30'd0, st0}, 32'd1);
    chk("resume_pc", pc0, 32'h8);
    resume = 0;
    tick();
    chk("resume_inc", pc0, 32'hC);
    redirect = 1; tgt = 32'hFFFF_FFFC;
    tick();
    idle();
    tick();
    chk("wrap_pc", pc0, 32'h0);
    redirect = 1; tgt = 32'h80;
    tick();
    idle();
    #2 rst = 1;
    #1;
    model_reset();
    chk("async_rst_pc", pc0, 32'h0);
    chk("async_rst_epc", epc0, 32'h0);
    chk("async_rst_state", {30'd0, st0}, 32'd0);
    check_all();
    #3 rst = 0;
    tick();
    chk("reboot_hold", pc0, 32'h0);
    tick();
    chk("reboot_inc", pc0, 32'h4);
    for (int i = 0; i < 600; i++) begin
      trap_req = $urandom_range(0, 99) < 5;
      redirect = $urandom_range(0, 99) < 20;
      tgt = $urandom_range(0, 3) == 0 ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      halt_req = $urandom_range(0, 99) < 8;
      stall = $urandom_range(0, 99) < 20;
      resume = $urandom_range(0, 99) < 30;
      tick();
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1;
        #1;
        model_reset();
        check_all();
        #1 rst = 0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
